// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract accumulator slice.
//   state_e : IDLE -> EXEC -> RESP request/response sequence
//   OP_ADD  : in_op encoding for add
//   OP_SUB  : in_op encoding for subtract
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_subtractor.sv
// Combinational WIDTH-bit adder/subtractor.
//   a, b : operands
//   k    : 0 = a + b, 1 = a - b (two's complement, a + ~b + 1)
//   sum  : result modulo 2^WIDTH
//   cout : carry out; for subtract, 1 means a >= b (no borrow)
module adder_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             k,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    always_comb begin
        b_eff = k ? ~b : b;
        // k doubles as the +1 of the two's-complement negation
        full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, k};
        sum   = full[WIDTH-1:0];
        cout  = full[WIDTH];
    end

endmodule

// File: rtl/addsub_accumulator.sv
// Handshaked add/subtract accumulator.
// One request is taken in IDLE, applied to the accumulator in EXEC, and the
// result is held in RESP until the consumer takes it (3 cycles per operation).
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : request handshake (in_ready only in IDLE)
//   in_op, in_clr       : 0 = add / 1 = subtract; clr loads in_data instead
//   in_data             : operand
//   out_valid/out_ready : response handshake
//   out_acc, out_cout   : accumulator and carry of the last operation
//   ovf_sticky          : set by add carry or subtract borrow, cleared by clr
//   op_count            : completed responses, wraps at 256
// Build option: define ADDSUB_ACC_SAT_EN to saturate instead of wrapping
// (add overflow -> all ones, subtract borrow -> 0).
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic             in_clr,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_cout,
    output logic             ovf_sticky,
    output logic [7:0]       op_count
);

    state_e           state_q;
    logic [WIDTH-1:0] opnd_q;
    logic             op_q;
    logic             clr_q;
    logic [WIDTH-1:0] acc_q;
    logic             cout_q;
    logic             ovf_q;
    logic             valid_q;
    logic [7:0]       count_q;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] acc_next;
    logic             ovf_set;

    adder_subtractor #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a    (acc_q),
        .b    (opnd_q),
        .k    (op_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        // add overflows on carry, subtract underflows on missing carry
        ovf_set  = (op_q == OP_ADD) ? add_cout : ~add_cout;
        acc_next = add_sum;
`ifdef ADDSUB_ACC_SAT_EN
        if (ovf_set) begin
            acc_next = (op_q == OP_ADD) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            op_q    <= OP_ADD;
            clr_q   <= 1'b0;
            acc_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            count_q <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        opnd_q  <= in_data;
                        op_q    <= in_op;
                        clr_q   <= in_clr;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (clr_q) begin
                        acc_q  <= opnd_q;
                        cout_q <= 1'b0;
                        ovf_q  <= 1'b0;
                    end else begin
                        acc_q  <= acc_next;
                        cout_q <= add_cout;
                        if (ovf_set) begin
                            ovf_q <= 1'b1;
                        end
                    end
                    valid_q <= 1'b1;
                    state_q <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        count_q <= count_q + 8'd1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = valid_q;
    assign out_acc    = acc_q;
    assign out_cout   = cout_q;
    assign ovf_sticky = ovf_q;
    assign op_count   = count_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Randomized self-checking bench for addsub_accumulator (WIDTH = 4) with a
// plain-arithmetic reference model of the accumulator.
module tb_addsub_accumulator;

    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;
`ifdef ADDSUB_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_op;
    logic         in_clr;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_acc;
    logic         out_cout;
    logic         ovf_sticky;
    logic [7:0]   op_count;

    addsub_accumulator #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_clr     (in_clr),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_acc    (out_acc),
        .out_cout   (out_cout),
        .ovf_sticky (ovf_sticky),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // reference state
    int m_acc   = 0;
    int m_cout  = 0;
    int m_ovf   = 0;
    int m_count = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_op(input bit op, input bit clr, input int data);
        int s;
        if (clr) begin
            m_acc  = data;
            m_cout = 0;
            m_ovf  = 0;
        end else if (op == 1'b0) begin
            s      = m_acc + data;
            m_cout = (s > MAX) ? 1 : 0;
            if (m_cout == 1) m_ovf = 1;
            m_acc  = (SAT && m_cout == 1) ? MAX : s % (MAX + 1);
        end else begin
            m_cout = (m_acc >= data) ? 1 : 0;
            if (m_cout == 0) m_ovf = 1;
            m_acc  = (SAT && m_cout == 0) ? 0 : (m_acc - data + MAX + 1) % (MAX + 1);
        end
    endfunction

    function automatic void model_reset();
        m_acc   = 0;
        m_cout  = 0;
        m_ovf   = 0;
        m_count = 0;
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, "_acc"},  32'(out_acc),    32'(m_acc));
        check_eq({tag, "_cout"}, 32'(out_cout),   32'(m_cout));
        check_eq({tag, "_ovf"},  32'(ovf_sticky), 32'(m_ovf));
        check_eq({tag, "_cnt"},  32'(op_count),   32'(m_count % 256));
    endtask

    // One full transaction. The handshake is visible during the cycle after
    // edge N; it is captured at N+1, and out_valid must be high after N+2.
    // hold: cycles out_ready stays low in RESP; busy: keep in_valid high
    // with scrambled request fields while the DUT is busy.
    task automatic do_op(input bit op, input bit clr, input logic [W-1:0] data,
                         input int hold, input bit busy, input string tag);
        logic [W-1:0] held;
        @(negedge clk);
        check_eq({tag, "_rdy_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_op     = op;
        in_clr    = clr;
        in_data   = data;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = busy;
        in_op    = 1'($urandom);
        in_clr   = 1'($urandom);
        in_data  = W'($urandom);
        check_eq({tag, "_vld_exec"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_rdy_exec"}, 32'(in_ready),  32'd0);
        @(posedge clk);
        model_op(op, clr, int'(data));
        @(negedge clk);
        check_eq({tag, "_vld_resp"}, 32'(out_valid), 32'd1);
        check_outputs(tag);
        held = out_acc;
        for (int i = 0; i < hold; i++) begin
            in_data = W'($urandom);
            @(negedge clk);
            check_eq({tag, "_hold_acc"}, 32'(out_acc),   32'(held));
            check_eq({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
            check_eq({tag, "_hold_rdy"}, 32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        m_count++;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_vld_done"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_rdy_done"}, 32'(in_ready),  32'd1);
        check_outputs({tag, "_done"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 1'b0;
        in_clr    = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        #2;
        check_eq("rst_vld", 32'(out_valid), 32'd0);
        check_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // clr 5
        do_op(1'b0, 1'b1, 4'd5, 0, 1'b0, "clr5");
        check_eq("clr5_lit", 32'(out_acc), 32'd5);
        // 5 + 3 = 8, then 8 + 13 overflows
        do_op(1'b0, 1'b0, 4'd3, 0, 1'b0, "add3");
        check_eq("add3_lit", 32'(out_acc), 32'd8);
        do_op(1'b0, 1'b0, 4'd13, 0, 1'b0, "add13");
        check_eq("add13_lit",  32'(out_acc),    SAT ? 32'd15 : 32'd5);
        check_eq("add13_cout", 32'(out_cout),   32'd1);
        check_eq("add13_ovf",  32'(ovf_sticky), 32'd1);
        // 5 - 10 borrows
        do_op(1'b0, 1'b1, 4'd5, 0, 1'b0, "clr5b");
        do_op(1'b1, 1'b0, 4'd10, 0, 1'b0, "sub10");
        check_eq("sub10_lit",  32'(out_acc),    SAT ? 32'd0 : 32'd11);
        check_eq("sub10_cout", 32'(out_cout),   32'd0);
        check_eq("sub10_ovf",  32'(ovf_sticky), 32'd1);
        // 9 - 5 no borrow
        do_op(1'b0, 1'b1, 4'd9, 0, 1'b0, "clr9");
        do_op(1'b1, 1'b0, 4'd5, 0, 1'b0, "sub5");
        check_eq("sub5_lit",  32'(out_acc),  32'd4);
        check_eq("sub5_cout", 32'(out_cout), 32'd1);

        // stall in RESP with in_valid asserted
        do_op(1'b0, 1'b0, 4'd1, 5, 1'b1, "stall");

        // random traffic
        for (int i = 0; i < 60; i++) begin
            do_op(1'($urandom), ($urandom_range(3) == 0), W'($urandom),
                  int'($urandom_range(3)), 1'($urandom), "rnd");
        end

        // reset while in EXEC
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 1'b0;
        in_clr   = 1'b1;
        in_data  = 4'd7;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        #1;
        check_eq("rexec_vld", 32'(out_valid), 32'd0);
        check_outputs("rexec");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rexec_post_vld", 32'(out_valid), 32'd0);
            check_eq("rexec_post_rdy", 32'(in_ready),  32'd1);
            check_eq("rexec_post_cnt", 32'(op_count),  32'd0);
        end

        // op_count wrap after 256 completions from reset
        for (int i = 0; i < 256; i++) begin
            do_op(1'($urandom), ($urandom_range(3) == 0), W'($urandom), 0, 1'b0, "wrap");
            if (i == 254) check_eq("wrap_255", 32'(op_count), 32'd255);
        end
        check_eq("wrap_0", 32'(op_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/addsub_accumulator.md
ADDSUB_ACCUMULATOR -- requirements
Module: addsub_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 4, as the operand and accumulator width in bits.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request accepted this cycle if in_valid.
REQ-007 SHALL have port in_op  input  1  0 = add, 1 = subtract.
REQ-008 SHALL have port in_clr  input  1  1 = load in_data into the accumulator; in_op is ignored.
REQ-009 SHALL have port in_data  input  WIDTH  operand.
REQ-010 SHALL have port out_valid  output  1  result held.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port out_acc  output  WIDTH  accumulator value.
REQ-013 SHALL have port out_cout  output  1  carry out of the last operation.
REQ-014 SHALL have port ovf_sticky  output  1  sticky overflow/borrow flag.
REQ-015 SHALL have port op_count  output  8  count of completed responses.

Function
REQ-016 SHALL implement an FSM with states IDLE, EXEC and RESP.
REQ-017 SHALL drive in_ready = 1 only in IDLE, and move to EXEC on in_valid && in_ready, capturing in_data, in_op and in_clr.
REQ-018 SHALL, in EXEC for one cycle, register acc <= clr ? operand : acc +/- operand (modulo 2^WIDTH) and cout <= clr ? 0 : adder carry, then move to RESP.
REQ-019 SHALL define subtract carry as two's-complement carry (acc + ~operand + 1), so cout = 1 means acc >= operand.
REQ-020 SHALL hold out_valid = 1 in RESP with out_acc and out_cout stable, and move to IDLE with op_count incremented on out_ready.
REQ-021 SHALL give latency as: request accepted at edge N, out_valid high after edge N+2; maximum throughput is one operation per 3 cycles.
REQ-022 SHALL ignore out_ready outside RESP and in_valid outside IDLE; in_data may change freely after acceptance.
REQ-023 SHALL set ovf_sticky on add with cout = 1 or subtract with cout = 0, clear it on a clr operation, and let set win over nothing else.
REQ-024 SHALL let op_count wrap from 255 to 0.
REQ-025 SHALL keep out_acc driven from the accumulator register in every state.

Reset
REQ-026 SHALL, on rst_n low and asynchronously, force state IDLE, acc = 0, out_cout = 0, ovf_sticky = 0, op_count = 0 and out_valid = 0; in_ready is 1 after release.
REQ-027 SHALL, on reset asserted in EXEC or RESP, abandon the operation with no response and no count increment.

Configuration
REQ-028 SHALL use macro ADDSUB_ACC_SAT_EN: when defined, overflowing add saturates acc to all-ones and borrowing subtract saturates to 0, with out_cout and ovf_sticky unchanged in meaning; when undefined, wrap-around as in REQ-018.

Structure
REQ-029 SHALL place the state typedef (IDLE/EXEC/RESP) and constants OP_ADD = 0, OP_SUB = 1 in shared package addsub_pkg.
REQ-030 SHALL compute the sum through one instance of existing combinational sub-module adder_subtractor (A = acc, B = operand, K = op); the FSM and registers live in this module.

Verification
REQ-031 SHALL check: reset, then clr with in_data 5 -> out_acc 5, out_cout 0, ovf_sticky 0, out_valid two edges after acceptance.
REQ-032 SHALL check: from 5, add 3 -> 8, cout 0; then add 13 -> 5, cout 1, ovf_sticky 1 (SAT_EN: 15).
REQ-033 SHALL check: from 5, sub 10 -> 11, cout 0, ovf_sticky 1 (SAT_EN: 0); from 9, sub 5 -> 4, cout 1.
REQ-034 SHALL check: out_ready held low 5 cycles in RESP with in_valid high -> out_acc stable, in_ready 0, no second acceptance.
REQ-035 SHALL check: rst_n pulsed low in EXEC -> all outputs at reset values immediately, no out_valid, op_count 0.
REQ-036 SHALL check: 256 completed operations -> op_count wraps to 0.
